// File: rtl/briscv_mem_arbiter_if.sv
// briscv_mem_arbiter_if: core-side request/response ports and the shared data-memory port
interface briscv_mem_arbiter_if #(
  parameter int NUM_PORTS    = 4,
  parameter int DATA_WIDTH   = 32,
  parameter int ADDRESS_BITS = 32
);
  logic [NUM_PORTS-1:0]                port_read;
  logic [NUM_PORTS-1:0]                port_write;
  logic [NUM_PORTS*DATA_WIDTH/8-1:0]   port_byte_en;
  logic [NUM_PORTS*ADDRESS_BITS-1:0]   port_address;
  logic [NUM_PORTS*DATA_WIDTH-1:0]     port_data;
  logic [NUM_PORTS-1:0]                port_ready;
  logic [NUM_PORTS-1:0]                port_valid;
  logic [DATA_WIDTH-1:0]               port_data_out;
  logic [ADDRESS_BITS-1:0]             port_address_out;
  logic                                mem_read;
  logic                                mem_write;
  logic [DATA_WIDTH/8-1:0]             mem_byte_en;
  logic [ADDRESS_BITS-1:0]             mem_address;
  logic [DATA_WIDTH-1:0]               mem_data;
  logic                                mem_ready;
  logic                                mem_valid;
  logic [DATA_WIDTH-1:0]               mem_data_in;
  logic [ADDRESS_BITS-1:0]             mem_address_in;
  modport master (
    output port_read, port_write, port_byte_en, port_address, port_data,
    output mem_ready, mem_valid, mem_data_in, mem_address_in,
    input  port_ready, port_valid, port_data_out, port_address_out,
    input  mem_read, mem_write, mem_byte_en, mem_address, mem_data
  );
  modport slave (
    input  port_read, port_write, port_byte_en, port_address, port_data,
    input  mem_ready, mem_valid, mem_data_in, mem_address_in,
    output port_ready, port_valid, port_data_out, port_address_out,
    output mem_read, mem_write, mem_byte_en, mem_address, mem_data
  );
endinterface

// File: rtl/briscv_mem_arbiter.sv
// briscv_mem_arbiter: shares one data-memory port among NUM_PORTS cores, one transaction in flight
module briscv_mem_arbiter #(
  parameter int NUM_PORTS    = 4,
  parameter int DATA_WIDTH   = 32,
  parameter int ADDRESS_BITS = 32,
  parameter int ARB_MODE     = 0
) (
  input  logic                         clock,
  input  logic                         reset,
  briscv_mem_arbiter_if.slave          bus,
  output logic [$clog2(NUM_PORTS)-1:0] owner,
  output logic                         busy,
  output logic                         protocol_error
);
  localparam int OW = $clog2(NUM_PORTS);
  localparam int BW = DATA_WIDTH / 8;
  typedef enum logic [1:0] {IDLE, ISSUE, WAIT_RD} state_t;
  state_t                  state_q, state_d;
  logic [OW-1:0]           ptr_q, ptr_d, owner_q, owner_d, win, i;
  logic                    rd_q, rd_d, wr_q, wr_d, perr_q, perr_d, found;
  logic [BW-1:0]           be_q, be_d;
  logic [ADDRESS_BITS-1:0] addr_q, addr_d;
  logic [DATA_WIDTH-1:0]   data_q, data_d;
  logic [NUM_PORTS-1:0]    req, ready, valid;
  int                      start;
  // winner search: fixed priority is a round-robin scan that always starts just after the last port
  always_comb begin
    req   = bus.port_read | bus.port_write;
    start = ARB_MODE != 0 ? NUM_PORTS - 1 : int'(ptr_q);
    found = 1'b0;
    win   = '0;
    i     = '0;
    for (int k = 1; k <= NUM_PORTS; k++) begin
      i = OW'((start + k) % NUM_PORTS);
      if (!found && req[i]) begin
        found = 1'b1;
        win   = i;
      end
    end
  end
  // FSM next state, command latch and per-port strobes
  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    owner_d = owner_q;
    rd_d    = rd_q;
    wr_d    = wr_q;
    be_d    = be_q;
    addr_d  = addr_q;
    data_d  = data_q;
    perr_d  = perr_q | (bus.mem_valid && state_q != WAIT_RD);
    ready   = '0;
    valid   = '0;
    case (state_q)
      IDLE: if (found) begin
        ready[win] = 1'b1;
        wr_d       = bus.port_write[win];
        rd_d       = ~bus.port_write[win];
        be_d       = bus.port_byte_en[win*BW +: BW];
        addr_d     = bus.port_address[win*ADDRESS_BITS +: ADDRESS_BITS];
        data_d     = bus.port_data[win*DATA_WIDTH +: DATA_WIDTH];
        owner_d    = win;
        ptr_d      = win;
        state_d    = ISSUE;
      end
      ISSUE: if (bus.mem_ready) begin
        rd_d    = 1'b0;
        wr_d    = 1'b0;
        state_d = rd_q ? WAIT_RD : IDLE;
      end
      WAIT_RD: begin
        valid[owner_q] = bus.mem_valid;
        state_d        = bus.mem_valid ? IDLE : WAIT_RD;
      end
      default: state_d = IDLE;
    endcase
  end
  // state registers; reset drops any command and pending response immediately
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
      ptr_q   <= OW'(NUM_PORTS - 1);
      owner_q <= '0;
      rd_q    <= 1'b0;
      wr_q    <= 1'b0;
      be_q    <= '0;
      addr_q  <= '0;
      data_q  <= '0;
      perr_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      owner_q <= owner_d;
      rd_q    <= rd_d;
      wr_q    <= wr_d;
      be_q    <= be_d;
      addr_q  <= addr_d;
      data_q  <= data_d;
      perr_q  <= perr_d;
    end
  end
  assign bus.port_ready       = ready;
  assign bus.port_valid       = valid;
  assign bus.port_data_out    = bus.mem_data_in;
  assign bus.port_address_out = bus.mem_address_in;
  assign bus.mem_read         = rd_q;
  assign bus.mem_write        = wr_q;
  assign bus.mem_byte_en      = be_q;
  assign bus.mem_address      = addr_q;
  assign bus.mem_data         = data_q;
  assign owner                = owner_q;
  assign busy                 = state_q != IDLE;
  assign protocol_error       = perr_q;
endmodule

// File: tb/tb_briscv_mem_arbiter.sv
// tb_briscv_mem_arbiter: directed checks of round-robin and fixed-priority arbiter instances
module tb_briscv_mem_arbiter;
  logic clock, reset;
  logic [1:0] own0, own1;
  logic busy0, busy1, perr0, perr1;
  int total, passed, failed;
  int exp_order [5] = '{0, 1, 2, 3, 0};
  briscv_mem_arbiter_if #(.NUM_PORTS(4), .DATA_WIDTH(32), .ADDRESS_BITS(32)) b0 ();
  briscv_mem_arbiter_if #(.NUM_PORTS(4), .DATA_WIDTH(32), .ADDRESS_BITS(32)) b1 ();
  briscv_mem_arbiter #(.NUM_PORTS(4), .DATA_WIDTH(32), .ADDRESS_BITS(32), .ARB_MODE(0)) u_rr (
    .clock(clock), .reset(reset), .bus(b0), .owner(own0), .busy(busy0), .protocol_error(perr0));
  briscv_mem_arbiter #(.NUM_PORTS(4), .DATA_WIDTH(32), .ADDRESS_BITS(32), .ARB_MODE(1)) u_fp (
    .clock(clock), .reset(reset), .bus(b1), .owner(own1), .busy(busy1), .protocol_error(perr1));
  initial begin
    clock = 1'b0;
    forever #5 clock = ~clock;
  end
  task automatic tick();
    @(posedge clock);
    #1;
  endtask
  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) passed++;
    else begin
      failed++;
      $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask
  initial begin
    total = 0; passed = 0; failed = 0;
    reset = 1'b0;
    b0.port_read = '0; b0.port_write = '0; b0.port_byte_en = '0; b0.port_address = '0; b0.port_data = '0;
    b0.mem_ready = 1'b0; b0.mem_valid = 1'b0; b0.mem_data_in = '0; b0.mem_address_in = '0;
    b1.port_read = '0; b1.port_write = '0; b1.port_byte_en = '0; b1.port_address = '0; b1.port_data = '0;
    b1.mem_ready = 1'b0; b1.mem_valid = 1'b0; b1.mem_data_in = '0; b1.mem_address_in = '0;
    tick(); tick();
    chk("rst_owner", 64'(own0), 0);
    chk("rst_busy", 64'(busy0), 0);
    chk("rst_perr", 64'(perr0), 0);
    chk("rst_mem_cmd", 64'({b0.mem_read, b0.mem_write}), 0);
    chk("rst_mem_addr", 64'(b0.mem_address), 0);
    chk("rst_ready", 64'(b0.port_ready), 0);
    reset = 1'b1;
    tick();
    // port 2 write
    b0.port_write[2] = 1'b1;
    b0.port_address[2*32 +: 32] = 32'h40;
    b0.port_data[2*32 +: 32] = 32'hDEADBEEF;
    b0.port_byte_en[2*4 +: 4] = 4'hF;
    #1;
    chk("wr_ready", 64'(b0.port_ready), 64'h4);
    chk("wr_busy_idle", 64'(busy0), 0);
    tick();
    b0.port_write = '0;
    #1;
    chk("wr_ready_pulse", 64'(b0.port_ready), 0);
    chk("wr_cmd", 64'({b0.mem_read, b0.mem_write}), 64'h1);
    chk("wr_addr", 64'(b0.mem_address), 64'h40);
    chk("wr_data", 64'(b0.mem_data), 64'hDEADBEEF);
    chk("wr_be", 64'(b0.mem_byte_en), 64'hF);
    chk("wr_owner", 64'(own0), 2);
    b0.mem_ready = 1'b1;
    tick();
    b0.mem_ready = 1'b0;
    chk("wr_done_busy", 64'(busy0), 0);
    chk("wr_done_cmd", 64'(b0.mem_write), 0);
    // port 1 read with a slow memory
    b0.port_read[1] = 1'b1;
    b0.port_address[1*32 +: 32] = 32'h100;
    #1;
    chk("rd_ready", 64'(b0.port_ready), 64'h2);
    tick();
    b0.port_read = '0;
    for (int c = 0; c < 3; c++) begin
      chk("rd_hold_cmd", 64'({b0.mem_read, b0.mem_write}), 64'h2);
      chk("rd_hold_addr", 64'(b0.mem_address), 64'h100);
      tick();
    end
    b0.mem_ready = 1'b1;
    tick();
    b0.mem_ready = 1'b0;
    chk("rd_wait_cmd", 64'(b0.mem_read), 0);
    chk("rd_wait_busy", 64'(busy0), 1);
    chk("rd_wait_valid", 64'(b0.port_valid), 0);
    tick();
    chk("rd_wait_valid2", 64'(b0.port_valid), 0);
    b0.mem_valid = 1'b1;
    b0.mem_data_in = 32'hCAFEF00D;
    b0.mem_address_in = 32'h100;
    #1;
    chk("rd_valid", 64'(b0.port_valid), 64'h2);
    chk("rd_data", 64'(b0.port_data_out), 64'hCAFEF00D);
    chk("rd_addr_out", 64'(b0.port_address_out), 64'h100);
    chk("rd_owner", 64'(own0), 1);
    tick();
    b0.mem_valid = 1'b0;
    chk("rd_done_valid", 64'(b0.port_valid), 0);
    chk("rd_done_busy", 64'(busy0), 0);
    chk("rd_no_perr", 64'(perr0), 0);
    // round-robin with all ports writing, fresh pointer
    reset = 1'b0;
    #1;
    reset = 1'b1;
    tick();
    b0.port_write = 4'hF;
    b0.mem_ready = 1'b1;
    for (int g = 0; g < 5; g++) begin
      #1;
      chk("rr_ready", 64'(b0.port_ready), 64'(4'b1 << exp_order[g]));
      tick();
      chk("rr_issue_ready", 64'(b0.port_ready), 0);
      chk("rr_owner", 64'(own0), 64'(exp_order[g]));
      tick();
    end
    b0.port_write = '0;
    b0.mem_ready = 1'b0;
    tick();
    // fixed priority: port 1 starves port 3 until it drops
    b1.port_write = 4'b1010;
    b1.mem_ready = 1'b1;
    for (int g = 0; g < 3; g++) begin
      #1;
      chk("fp_ready", 64'(b1.port_ready), 64'h2);
      tick();
      chk("fp_owner", 64'(own1), 1);
      tick();
    end
    b1.port_write = 4'b1000;
    #1;
    chk("fp_ready_p3", 64'(b1.port_ready), 64'h8);
    tick();
    b1.port_write = '0;
    chk("fp_owner_p3", 64'(own1), 3);
    tick();
    b1.mem_ready = 1'b0;
    // unexpected response in IDLE
    b0.mem_valid = 1'b1;
    #1;
    chk("perr_no_valid", 64'(b0.port_valid), 0);
    tick();
    b0.mem_valid = 1'b0;
    chk("perr_set", 64'(perr0), 1);
    tick();
    chk("perr_sticky", 64'(perr0), 1);
    // reset during WAIT_RD
    b0.port_read[3] = 1'b1;
    #1;
    chk("ab_ready", 64'(b0.port_ready), 64'h8);
    tick();
    b0.port_read = '0;
    b0.mem_ready = 1'b1;
    tick();
    b0.mem_ready = 1'b0;
    chk("ab_busy", 64'(busy0), 1);
    #2;
    b0.mem_valid = 1'b1;
    reset = 1'b0;
    #1;
    chk("ab_busy_rst", 64'(busy0), 0);
    chk("ab_valid_rst", 64'(b0.port_valid), 0);
    chk("ab_owner_rst", 64'(own0), 0);
    chk("ab_perr_rst", 64'(perr0), 0);
    chk("ab_cmd_rst", 64'({b0.mem_read, b0.mem_write}), 0);
    tick();
    b0.mem_valid = 1'b0;
    reset = 1'b1;
    b0.port_write = 4'b0011;
    #1;
    chk("ab_first_grant", 64'(b0.port_ready), 64'h1);
    tick();
    b0.port_write = '0;
    chk("ab_first_owner", 64'(own0), 0);
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
